// File: rtl/scanchain_prog_ctrl_if.sv
// Host-side configuration word stream: data/valid from the host, ready from the loader.
interface scanchain_prog_ctrl_if #(
   parameter int WORD_WIDTH = 32
);
   logic [WORD_WIDTH-1:0] cfg_data;
   logic                  cfg_valid;
   logic                  cfg_ready;

   modport master (
      output cfg_data,
      output cfg_valid,
      input  cfg_ready
   );

   modport slave (
      input  cfg_data,
      input  cfg_valid,
      output cfg_ready
   );
endinterface

// File: rtl/scanchain_prog_ctrl.sv
// Bitstream loader for the CLB scan chain: accepts host words, shifts them MSB-first
// onto prog_din/prog_we and raises prog_done after exactly CHAIN_LENGTH bits.
module scanchain_prog_ctrl #(
   parameter int CHAIN_LENGTH = 1024,
   parameter int WORD_WIDTH   = 32
) (
   input  logic                              prog_clk,
   input  logic                              prog_rst,
   scanchain_prog_ctrl_if.slave              cfg,
   input  logic                              cfg_start,
   output logic                              cfg_busy,
   output logic [$clog2(CHAIN_LENGTH+1)-1:0] bit_count,
   output logic                              prog_din,
   output logic                              prog_we,
   output logic                              prog_done,
   input  logic                              prog_dout,
   input  logic                              prog_we_o
);

   localparam int BCW = $clog2(CHAIN_LENGTH + 1);
   localparam int SCW = $clog2(WORD_WIDTH + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(CHAIN_LENGTH);
   localparam logic [SCW-1:0] FULL_CNT = SCW'(WORD_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [WORD_WIDTH-1:0] sr_q, sr_d;
   logic [SCW-1:0]        sr_cnt_q, sr_cnt_d;
   logic [WORD_WIDTH-1:0] pend_q, pend_d;
   logic                  pend_full_q, pend_full_d;
   logic [BCW-1:0]        bit_count_q, bit_count_d;
   logic                  prog_din_q, prog_din_d;
   logic                  prog_we_q, prog_we_d;
   logic                  prog_done_q, prog_done_d;
   logic                  cfg_busy_q, cfg_busy_d;
   logic                  accept;
   logic                  sr_draining;
   logic                  unused_chain_inputs;

   // Readback path is reserved; the chain outputs are intentionally not consumed.
   assign unused_chain_inputs = prog_dout ^ prog_we_o;

   assign cfg.cfg_ready = (state_q == ST_SHIFT) && !pend_full_q;
   assign accept        = cfg.cfg_valid && cfg.cfg_ready;

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      sr_cnt_d    = sr_cnt_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      bit_count_d = bit_count_q;
      prog_din_d  = prog_din_q;
      prog_we_d   = 1'b0;
      prog_done_d = prog_done_q;
      cfg_busy_d  = cfg_busy_q;
      sr_draining = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            prog_done_d = (state_q == ST_DONE);
            if (cfg_start) begin
               state_d     = ST_SHIFT;
               cfg_busy_d  = 1'b1;
               bit_count_d = '0;
               prog_done_d = 1'b0;
               sr_d        = '0;
               sr_cnt_d    = '0;
               pend_d      = '0;
               pend_full_d = 1'b0;
            end
         end

         ST_SHIFT: begin
            if (sr_cnt_q != '0) begin
               prog_din_d  = sr_q[WORD_WIDTH-1];
               prog_we_d   = 1'b1;
               sr_d        = sr_q << 1;
               sr_cnt_d    = sr_cnt_q - SCW'(1);
               bit_count_d = bit_count_q + BCW'(1);
            end

            // Refill on the same edge the last bit leaves so prog_we never bubbles.
            sr_draining = (sr_cnt_q <= SCW'(1));
            if (sr_draining && pend_full_q) begin
               sr_d        = pend_q;
               sr_cnt_d    = FULL_CNT;
               pend_full_d = 1'b0;
            end else if (accept) begin
               if (sr_draining) begin
                  sr_d     = cfg.cfg_data;
                  sr_cnt_d = FULL_CNT;
               end else begin
                  pend_d      = cfg.cfg_data;
                  pend_full_d = 1'b1;
               end
            end

            // Final chain bit: leftover buffered bits are dropped.
            if ((sr_cnt_q != '0) && (bit_count_d == LAST_BIT)) begin
               state_d     = ST_DONE;
               cfg_busy_d  = 1'b0;
               sr_d        = '0;
               sr_cnt_d    = '0;
               pend_d      = '0;
               pend_full_d = 1'b0;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            cfg_busy_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge prog_clk or negedge prog_rst) begin
      if (!prog_rst) begin
         state_q     <= ST_IDLE;
         sr_q        <= '0;
         sr_cnt_q    <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         bit_count_q <= '0;
         prog_din_q  <= 1'b0;
         prog_we_q   <= 1'b0;
         prog_done_q <= 1'b0;
         cfg_busy_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         sr_cnt_q    <= sr_cnt_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         bit_count_q <= bit_count_d;
         prog_din_q  <= prog_din_d;
         prog_we_q   <= prog_we_d;
         prog_done_q <= prog_done_d;
         cfg_busy_q  <= cfg_busy_d;
      end
   end

   assign cfg_busy  = cfg_busy_q;
   assign bit_count = bit_count_q;
   assign prog_din  = prog_din_q;
   assign prog_we   = prog_we_q;
   assign prog_done = prog_done_q;

endmodule
